// File: rtl/cdc_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_tx_frame_arbiter
//
// Round-robin arbiter and packetizer between NUM_CH capture FIFOs
// (UART/SPI/I2C) and the single USB CDC TX byte stream. One non-empty FIFO is
// granted, up to MAX_BURST bytes are drained into a local buffer, and then a
// frame is sent over a valid/ready byte interface:
//   SYNC_BYTE, CH_ID, LEN, payload[LEN], CHK
// CHK = (CH_ID + LEN + sum(payload)) mod 256. SYNC_BYTE is not included.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset; aborts any frame in progress
//   ch_rempty  per-channel FIFO empty flags
//   ch_rdata   per-channel show-ahead FIFO head, channel i at [8i+7:8i]
//   ch_rinc    per-channel FIFO pop strobe, one-hot or zero
//   tx_data    frame byte towards the USB CDC TX path
//   tx_valid   tx_data is valid
//   tx_ready   sink accepts the byte when tx_valid && tx_ready
//   busy       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module cdc_tx_frame_arbiter #(
  parameter int                    NUM_CH     = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_BURST  = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_rempty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
  output logic [NUM_CH-1:0]            ch_rinc,
  output logic [DATA_WIDTH-1:0]        tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int BUF_AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SYNC,
    S_ID,
    S_LEN,
    S_DATA,
    S_CHK
  } state_e;

  state_e                  state_q;
  logic [CH_W-1:0]         grant_q;
  logic [CH_W-1:0]         last_grant_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   chk_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic [DATA_WIDTH-1:0]   buf_q [MAX_BURST];

  logic                    any_req_d;
  logic [CH_W-1:0]         grant_d;
  logic [CH_W-1:0]         rr_idx_d;
  logic [DATA_WIDTH-1:0]   head_d;
  logic                    gnt_empty_d;
  logic                    pop_d;
  logic                    accept_d;

  // Round-robin search starting one past the last grant. Iterating from the
  // farthest candidate down lets the nearest non-empty channel win by being
  // written last.
  // NOTE: every combinational output gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    any_req_d = |(~ch_rempty);
    grant_d   = last_grant_q;
    rr_idx_d  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_idx_d = CH_W'((int'(last_grant_q) + i) % NUM_CH);
      if (!ch_rempty[rr_idx_d]) grant_d = rr_idx_d;
    end
  end

  // Head byte and empty flag of the granted channel.
  always_comb begin
    head_d      = '0;
    gnt_empty_d = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_W'(i)) begin
        head_d      = ch_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_empty_d = ch_rempty[i];
      end
    end
  end

  // Pops are decided from registered state only, so they can never reach a
  // non-granted channel or run outside COLLECT.
  assign pop_d    = (state_q == S_COLLECT) && !gnt_empty_d && (cnt_q < CNT_W'(MAX_BURST));
  assign accept_d = tx_valid_q && tx_ready;

  always_comb begin
    ch_rinc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rinc[i] = pop_d && (grant_q == CH_W'(i));
    end
  end

  // NOTE: the payload buffer carries no reset; LEN bounds every read to bytes
  // written during the current frame, so stale contents are never sent.
  always_ff @(posedge clk) begin
    if (pop_d) buf_q[BUF_AW'(cnt_q)] <= head_d;
  end

  // Frame FSM. tx_data/tx_valid are loaded with the byte of the state being
  // entered, so they stay stable while the sink stalls. The checksum is
  // seeded with the channel id and gains (byte + 1) per pop, which folds LEN
  // in without a final addition.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      idx_q        <= '0;
      chk_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= '0;
            chk_q        <= DATA_WIDTH'(grant_d);
            state_q      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (pop_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
            chk_q <= chk_q + head_d + DATA_WIDTH'(1);
          end else begin
            state_q    <= S_SYNC;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC_BYTE;
          end
        end
        S_SYNC: begin
          if (accept_d) begin
            state_q   <= S_ID;
            tx_data_q <= DATA_WIDTH'(grant_q);
          end
        end
        S_ID: begin
          if (accept_d) begin
            state_q   <= S_LEN;
            tx_data_q <= DATA_WIDTH'(cnt_q);
          end
        end
        S_LEN: begin
          if (accept_d) begin
            state_q   <= S_DATA;
            idx_q     <= '0;
            tx_data_q <= buf_q[BUF_AW'(0)];
          end
        end
        S_DATA: begin
          if (accept_d) begin
            if (idx_q == cnt_q - CNT_W'(1)) begin
              state_q   <= S_CHK;
              tx_data_q <= chk_q;
            end else begin
              idx_q     <= idx_q + CNT_W'(1);
              tx_data_q <= buf_q[BUF_AW'(idx_q + CNT_W'(1))];
            end
          end
        end
        S_CHK: begin
          if (accept_d) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cdc_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_tx_frame_arbiter
//
// Bench for cdc_tx_frame_arbiter. Behavioural show-ahead FIFOs feed the
// channel ports; a sink consumes tx bytes and compares each accepted byte
// against a scoreboard of expected frames built when the stimulus is loaded.
// -----------------------------------------------------------------------------
module tb_cdc_tx_frame_arbiter;

  localparam int NUM_CH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_CH-1:0]   ch_rempty;
  logic [NUM_CH*8-1:0] ch_rdata;
  logic [NUM_CH-1:0]   ch_rinc;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready = 1'b1;
  logic                busy;

  cdc_tx_frame_arbiter #(
    .NUM_CH    (NUM_CH),
    .DATA_WIDTH(8),
    .MAX_BURST (16),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_rempty(ch_rempty),
    .ch_rdata (ch_rdata),
    .ch_rinc  (ch_rinc),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]        fifo_q [NUM_CH][$];
  logic [7:0]        exp_q [$];
  logic [NUM_CH-1:0] pend_pop = '0;
  int                pop_cnt [NUM_CH];
  int                checks = 0;
  int                errors = 0;
  int                acc_cnt = 0;
  bit                rand_ready = 1'b0;
  bit                hold_pending = 1'b0;
  logic [7:0]        held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rempty[i]       = (fifo_q[i].size() == 0);
      ch_rdata[i*8 +: 8] = (fifo_q[i].size() == 0) ? 8'h00 : fifo_q[i][0];
    end
  endtask

  // Push len bytes first, first+step, ... into channel ch.
  task automatic load(input int ch, input logic [7:0] first, input logic [7:0] step, input int len);
    logic [7:0] b;
    b = first;
    for (int k = 0; k < len; k++) begin
      fifo_q[ch].push_back(b);
      b = b + step;
    end
    refresh();
  endtask

  // Scoreboard: append the full expected frame for the given payload.
  task automatic expect_frame(input int ch, input logic [7:0] first, input logic [7:0] step, input int len);
    logic [7:0] b;
    logic [7:0] chk;
    b   = first;
    chk = 8'(ch) + 8'(len);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(b);
      chk = chk + b;
      b   = b + step;
    end
    exp_q.push_back(chk);
  endtask

  // FIFO model: outputs refreshed on the falling edge, pop request sampled
  // 1 time unit later, pop applied on the next rising edge.
  always @(negedge clk) begin
    refresh();
    #1;
    pend_pop = ch_rinc;
    if (ch_rinc != '0) begin
      check("rinc_onehot", {31'b0, $onehot(ch_rinc)}, 32'd1);
      for (int i = 0; i < NUM_CH; i++)
        if (ch_rinc[i]) check("rinc_nonempty", {31'b0, fifo_q[i].size() != 0}, 32'd1);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_pop[i] && fifo_q[i].size() > 0) begin
        void'(fifo_q[i].pop_front());
        pop_cnt[i]++;
      end
    end
    pend_pop = '0;
  end

  // Sink: choose tx_ready for the coming edge, then judge the byte on offer.
  always @(negedge clk) begin
    tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    #1;
    if (tx_valid) begin
      if (hold_pending) check("tx_hold_stable", tx_data, held);
      if (tx_ready) begin
        acc_cnt++;
        hold_pending = 1'b0;
        if (exp_q.size() == 0) check("tx_extra_byte", exp_q.size(), 32'd1);
        else                   check("tx_byte", tx_data, exp_q.pop_front());
      end else begin
        hold_pending = 1'b1;
        held         = tx_data;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 32'd0);
    check({tag, "_tx_data"},  tx_data,  32'd0);
    check({tag, "_busy"},     busy,     32'd0);
    check({tag, "_ch_rinc"},  ch_rinc,  32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // which: 0 = tx_valid, 1 = busy. An expired budget is a failed check.
  task automatic wait_sig(input string tag, input int which, input logic level, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      #2;
      hit = (((which == 0) ? tx_valid : busy) == level);
    end
    check(tag, {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      #2;
      hit = (exp_q.size() == 0) && !busy;
    end
    check({tag, "_drained"}, {31'b0, hit}, 32'd1);
    check({tag, "_busy_after"}, busy, 32'd0);
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int target;
    bit hit;
    target = acc_cnt + n;
    hit    = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      #2;
      hit = (acc_cnt >= target);
    end
    check(tag, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) pop_cnt[i] = 0;
    refresh();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("por");
    #1 rst_n = 1'b1;

    // 1: ch1 holds 11,22,33 -> A5 01 03 11 22 33 6A
    @(negedge clk);
    expect_frame(1, 8'h11, 8'h11, 3);
    load(1, 8'h11, 8'h11, 3);
    wait_drain("t1", 200);
    check("t1_pops_ch1", pop_cnt[1], 32'd3);

    // 2: ch0 refilled every frame, ch2 deep -> ch0, ch2, ch0, ch2
    pulse_reset();
    @(negedge clk);
    expect_frame(0, 8'hC0, 8'h01, 2);
    expect_frame(2, 8'h40, 8'h01, 16);
    expect_frame(0, 8'hC2, 8'h01, 3);
    expect_frame(2, 8'h50, 8'h01, 4);
    load(0, 8'hC0, 8'h01, 2);
    load(2, 8'h40, 8'h01, 20);
    wait_sig("t2_f1_valid", 0, 1'b1, 100);
    @(negedge clk);
    load(0, 8'hC2, 8'h01, 2);
    wait_sig("t2_f1_done", 1, 1'b0, 100);
    wait_sig("t2_f2_valid", 0, 1'b1, 100);
    @(negedge clk);
    load(0, 8'hC4, 8'h01, 1);
    wait_drain("t2", 500);

    // 3: 20 bytes on ch3 split into LEN=16 and LEN=4 frames
    @(negedge clk);
    expect_frame(3, 8'h00, 8'h01, 16);
    expect_frame(3, 8'h10, 8'h01, 4);
    load(3, 8'h00, 8'h01, 20);
    wait_drain("t3", 500);
    check("t3_pops_ch3", pop_cnt[3], 32'd20);

    // 4: tests 1 and 3 again with a 30% tx_ready duty
    rand_ready = 1'b1;
    @(negedge clk);
    expect_frame(1, 8'h11, 8'h11, 3);
    expect_frame(3, 8'h00, 8'h01, 16);
    expect_frame(3, 8'h10, 8'h01, 4);
    load(1, 8'h11, 8'h11, 3);
    load(3, 8'h00, 8'h01, 20);
    wait_drain("t4", 3000);
    rand_ready = 1'b0;

    // 5: reset during DATA; buffered bytes lost, ch0 wins after release
    @(negedge clk);
    expect_frame(3, 8'h00, 8'h01, 16);
    load(3, 8'h00, 8'h01, 20);
    wait_acc("t5_in_data", 5, 200);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t5_abort");
    exp_q.delete();
    @(negedge clk);
    expect_frame(0, 8'h77, 8'h00, 1);
    expect_frame(3, 8'h10, 8'h01, 4);
    load(0, 8'h77, 8'h00, 1);
    #2 rst_n = 1'b1;
    wait_drain("t5", 500);

    // 6: all FIFOs empty for 100 cycles -> nothing moves
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #2;
      check("t6_tx_valid", tx_valid, 32'd0);
      check("t6_busy",     busy,     32'd0);
      check("t6_ch_rinc",  ch_rinc,  32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
